booth_radix2_multiplier: RTL
============================

Name: booth_radix2_multiplier

Overview:
Sequential radix-2 Booth multiplier, WIDTH x WIDTH unsigned. It is the inverse-direction companion to the team's radix-2 SRT divider: it rebuilds the dividend as quotient x divisor (+ remainder) for on-board self-check through the VIO probes.
It uses the same signed-digit recoding {-1,0,+1} and processes one digit per clock behind a start/busy/done handshake.

Parameters:
WIDTH, 8, operand width in bits; product width is 2*WIDTH.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
multiplicand  input  WIDTH  unsigned operand M (e.g. divisor), captured on accepted start
multiplier  input  WIDTH  unsigned operand Q (e.g. quotient), captured on accepted start
busy  output  1  high while iterating
done  output  1  one-cycle pulse; product valid from this cycle
product  output  2*WIDTH  result, held until the next done

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0; done=0; product=0; internal acc/Q/q_m1/count=0. Reset mid-operation aborts with no done pulse.
- FSM IDLE -> RUN -> DONE -> IDLE.
- IDLE, start=1 at edge k:
  - Load M9={1'b0,multiplicand}; acc=0 (WIDTH+1 bits); Q9={1'b0,multiplier}; q_m1=0; count=0.
  - Go to RUN.
- RUN, one Booth step per edge, WIDTH+1 steps (edges k+1..k+WIDTH+1). On each step, examine {Q9[0],q_m1}:
  - 01: acc=acc+M9.
  - 10: acc=acc-M9.
  - 00/11: no add.
  - Then arithmetic right shift of {acc,Q9,q_m1} by 1, replicating acc MSB. count++.
  - Leave for DONE after the step with count==WIDTH.
  - acc arithmetic is modulo 2^(WIDTH+1); no overflow is possible for zero-extended operands.
- DONE entry (same edge as the last RUN step registers): product={acc,Q9}[2*WIDTH-1:0] (+ addend, see feature).
- busy=1 exactly during RUN: cycles k+1..k+WIDTH+1.
- done=1 for exactly one cycle (cycle k+WIDTH+2). Latency start-to-done is WIDTH+2 cycles; WIDTH=8 gives 10.
- DONE -> IDLE unconditionally. start during DONE is ignored; back-to-back issue is one start per WIDTH+3 cycles.
- start while busy or in DONE: ignored, with no effect on operands or state.
- Operand inputs may change freely after the accepted start.
- product changes only on the DONE entry edge or reset.
- Boundaries:
  - Either operand 0 gives product 0.
  - Max 255x255 = 65025 fits 16 bits.
  - MSB-set operands are handled by the zero extension; no sign misinterpretation.

Optional Feature:
- Macro BOOTH_MUL_ADDEND_EN.
- Defined:
  - Extra input port addend (WIDTH bits), captured on accepted start.
  - product = M*Q + addend, modulo 2^(2*WIDTH); 255*255+255 = 65280 still fits.
  - The add is folded into DONE entry; latency is unchanged.
  - Intended use is reconstructing the dividend from quotient, divisor and remainder[WIDTH-1:0].
- Undefined: no addend port; product = M*Q.

Decomposition:
- Package booth_pkg:
  - State enum {IDLE, RUN, DONE}.
  - Localparam constants for widths (WIDTH+1 internal, 2*WIDTH product).
  - Step-count width $clog2(WIDTH+2).
- One natural sub-module, booth_step: combinational single Booth iteration.
  - Inputs: acc, Q9, q_m1, M9.
  - Outputs: next acc, Q9, q_m1.
  - Instantiated once inside the FSM datapath.

Test Plan:
- Reset then start with multiplicand=13, multiplier=11 at edge k -> busy high cycles k+1..k+9; done pulse at k+10; product=143; busy=0 afterwards.
- 255 x 255 -> product=65025. 128 x 2 -> 256. 0 x 200 -> 0. 1 x 1 -> 1. Each completes in exactly 10 cycles.
- Operands 7 x 9, re-asserting start and changing operands to 99 x 99 during busy -> single done; product=63; the second start is ignored.
- Pull rst_n low at cycle k+4 of an operation -> immediate busy=0, done=0, product=0; no later done; a new start after release gives a correct result.
- (BOOTH_MUL_ADDEND_EN) divisor=7, quotient=9, addend=3 -> product=66. 255 x 255 + 255 -> 65280.
- Random 1000 pairs checked against M*Q reference model. Check done is exactly one cycle, and product is stable between done pulses.

Source files
------------

// File: rtl/booth_pkg.sv
// booth_pkg: shared types and width constants for the radix-2 Booth multiplier.
//   state_t       FSM encoding (IDLE, RUN, DONE)
//   BOOTH_WIDTH   default operand width
//   ext_w/prod_w/cnt_w  helpers deriving internal widths from an operand width
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int BOOTH_WIDTH  = 8;
  localparam int BOOTH_EXT_W  = BOOTH_WIDTH + 1;
  localparam int BOOTH_PROD_W = 2 * BOOTH_WIDTH;
  localparam int BOOTH_CNT_W  = $clog2(BOOTH_WIDTH + 2);

  // Zero-extended operand / accumulator width.
  function automatic int ext_w(input int w);
    return w + 1;
  endfunction

  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

  // Step counter runs 0..w, sized with headroom to w+1.
  function automatic int cnt_w(input int w);
    return $clog2(w + 2);
  endfunction

endpackage

// File: rtl/booth_step.sv
// booth_step: one combinational radix-2 Booth iteration.
// Ports:
//   acc, q, q_m1, m        current accumulator, multiplier register, Booth
//                          history bit, zero-extended multiplicand
//   acc_nxt, q_nxt, q_m1_nxt  state after add/sub and arithmetic right shift
module booth_step #(
  parameter int EXT_W = 9
) (
  input  logic [EXT_W-1:0] acc,
  input  logic [EXT_W-1:0] q,
  input  logic             q_m1,
  input  logic [EXT_W-1:0] m,
  output logic [EXT_W-1:0] acc_nxt,
  output logic [EXT_W-1:0] q_nxt,
  output logic             q_m1_nxt
);

  logic [EXT_W-1:0] sum;

  // Recoded digit: 01 -> +1, 10 -> -1, 00/11 -> 0. Arithmetic wraps
  // modulo 2^EXT_W, which cannot overflow for zero-extended operands.
  always_comb begin
    sum = acc;
    case ({q[0], q_m1})
      2'b01:   sum = acc + m;
      2'b10:   sum = acc - m;
      default: sum = acc;
    endcase
  end

  // Shift {sum, q, q_m1} right by one, replicating the sign of sum.
  assign acc_nxt  = {sum[EXT_W-1], sum[EXT_W-1:1]};
  assign q_nxt    = {sum[0], q[EXT_W-1:1]};
  assign q_m1_nxt = q[0];

endmodule

// File: rtl/booth_radix2_multiplier.sv
// booth_radix2_multiplier: sequential WIDTH x WIDTH unsigned radix-2 Booth
// multiplier, one recoded digit per clock, start/busy/done handshake.
// Optional feature macro: BOOTH_MUL_ADDEND_EN adds an addend input folded
// into the product on DONE entry (product = M*Q + addend).
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   start         request, sampled only in IDLE
//   multiplicand  operand M, captured on accepted start
//   multiplier    operand Q, captured on accepted start
//   addend        (BOOTH_MUL_ADDEND_EN only) captured on accepted start
//   busy          high during RUN (WIDTH+1 cycles)
//   done          one-cycle pulse, product valid from this cycle
//   product       result, held until the next done
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one Booth step per clock, WIDTH+1 steps
// DONE  | product just registered, done pulse
module booth_radix2_multiplier
  import booth_pkg::*;
#(
  parameter int WIDTH = BOOTH_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
`ifdef BOOTH_MUL_ADDEND_EN
  input  logic [WIDTH-1:0]     addend,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int EXT_W  = ext_w(WIDTH);
  localparam int PROD_W = prod_w(WIDTH);
  localparam int CNT_W  = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);

  state_t             state, state_nxt;
  logic [EXT_W-1:0]   m_r, acc_r, q_r;
  logic               q_m1_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [PROD_W-1:0]  product_r;

  logic [EXT_W-1:0]   acc_nxt, q_nxt;
  logic               q_m1_nxt;
  logic [PROD_W-1:0]  prod_nxt;

`ifdef BOOTH_MUL_ADDEND_EN
  logic [WIDTH-1:0]   addend_r;
`endif

  booth_step #(.EXT_W(EXT_W)) u_step (
    .acc      (acc_r),
    .q        (q_r),
    .q_m1     (q_m1_r),
    .m        (m_r),
    .acc_nxt  (acc_nxt),
    .q_nxt    (q_nxt),
    .q_m1_nxt (q_m1_nxt)
  );

  // The top two accumulator bits are sign extension of a product that
  // always fits in PROD_W bits, so only the low PROD_W bits are kept.
`ifdef BOOTH_MUL_ADDEND_EN
  assign prod_nxt = {acc_nxt[WIDTH-2:0], q_nxt} + PROD_W'(addend_r);
`else
  assign prod_nxt = {acc_nxt[WIDTH-2:0], q_nxt};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (cnt_r == LAST_CNT) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_r       <= '0;
      acc_r     <= '0;
      q_r       <= '0;
      q_m1_r    <= 1'b0;
      cnt_r     <= '0;
      product_r <= '0;
`ifdef BOOTH_MUL_ADDEND_EN
      addend_r  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m_r      <= {1'b0, multiplicand};
            acc_r    <= '0;
            q_r      <= {1'b0, multiplier};
            q_m1_r   <= 1'b0;
            cnt_r    <= '0;
`ifdef BOOTH_MUL_ADDEND_EN
            addend_r <= addend;
`endif
          end
        end
        RUN: begin
          acc_r  <= acc_nxt;
          q_r    <= q_nxt;
          q_m1_r <= q_m1_nxt;
          cnt_r  <= cnt_r + CNT_W'(1);
          if (cnt_r == LAST_CNT) product_r <= prod_nxt;
        end
        default: ;
      endcase
    end
  end

  assign product = product_r;

endmodule
